duart_tx_ctrl: RTL

- Per-channel transmit controller for the DUART; sits between the CPU register interface and the serial transmitter core.
- Owns the transmit holding register (THR), the enable/disable/reset/break commands and the TxRDY/TxEMT status.
- Sequences byte handoff to the core over its DV/Active/Done handshake and owns the final TxD pin value.

---
 rtl/duart_tx_ctrl_if.sv | 24 ++
 rtl/duart_tx_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/duart_tx_ctrl_if.sv
// rtl/duart_tx_ctrl_if.sv - byte handoff bundle between the transmit controller and the serial core
interface duart_tx_ctrl_if;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_done;
  logic       tx_serial;

  modport master (
    output tx_dv,
    output tx_byte,
    input  tx_active,
    input  tx_done,
    input  tx_serial
  );

  modport slave (
    input  tx_dv,
    input  tx_byte,
    output tx_active,
    output tx_done,
    output tx_serial
  );
endinterface

// File: rtl/duart_tx_ctrl.sv
// rtl/duart_tx_ctrl.sv - DUART per-channel transmit controller; optional CTS gating under DUART_TX_CTS_EN
module duart_tx_ctrl #(
  parameter int GAP_CYCLES = 1
) (
  input  logic             i_Clock,
  input  logic             i_Rst_L,
  input  logic             i_Wr,
  input  logic [7:0]       i_Wr_Data,
  input  logic             i_Cmd_Valid,
  input  logic [2:0]       i_Cmd,
  input  logic             i_CTS_L,
  output logic             o_TxRDY,
  output logic             o_TxEMT,
  output logic             o_Wr_Drop,
  output logic             o_TXD,
  duart_tx_ctrl_if.master  core
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    SHIFTING   = 3'd2,
    GAP        = 3'd3,
    BREAK      = 3'd4,
    DRAIN      = 3'd5
  } state_t;

  localparam logic [2:0] CMD_ENABLE    = 3'b001;
  localparam logic [2:0] CMD_DISABLE   = 3'b010;
  localparam logic [2:0] CMD_RESET     = 3'b011;
  localparam logic [2:0] CMD_BRK_START = 3'b100;
  localparam logic [2:0] CMD_BRK_STOP  = 3'b101;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     state, state_nxt;
  logic       enable, enable_nxt;
  logic       thr_full, thr_full_nxt;
  logic [7:0] thr_data, thr_data_nxt;
  logic       brk_pend, brk_nxt;
  logic       drop_nxt;
  logic [3:0] gap_cnt, gap_nxt;
  logic       dv_q, dv_nxt;
  logic [7:0] byte_q, byte_nxt;
  logic       txd_src;
  logic       cts_ok;

  logic cmd_enable, cmd_disable, cmd_reset, cmd_brk_start, cmd_brk_stop;

  assign cmd_enable    = i_Cmd_Valid && (i_Cmd == CMD_ENABLE);
  assign cmd_disable   = i_Cmd_Valid && (i_Cmd == CMD_DISABLE);
  assign cmd_reset     = i_Cmd_Valid && (i_Cmd == CMD_RESET);
  assign cmd_brk_start = i_Cmd_Valid && (i_Cmd == CMD_BRK_START);
  assign cmd_brk_stop  = i_Cmd_Valid && (i_Cmd == CMD_BRK_STOP);

`ifdef DUART_TX_CTS_EN
  logic [1:0] cts_sync;

  // Bring the asynchronous clear-to-send into the clock domain; idles as "not clear".
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cts_sync <= 2'b11;
    end else begin
      cts_sync <= {cts_sync[0], i_CTS_L};
    end
  end

  assign cts_ok = ~cts_sync[1];
`else
  logic unused_cts;

  assign unused_cts = i_CTS_L;
  assign cts_ok     = 1'b1;
`endif

  // Next-state logic: commands take effect first, then the write, then the handoff sequencer.
  always_comb begin
    state_nxt    = state;
    enable_nxt   = enable;
    thr_full_nxt = thr_full;
    thr_data_nxt = thr_data;
    brk_nxt      = brk_pend;
    drop_nxt     = o_Wr_Drop;
    gap_nxt      = gap_cnt;
    dv_nxt       = 1'b0;
    byte_nxt     = byte_q;
    txd_src      = 1'b1;

    if (cmd_enable)              enable_nxt = 1'b1;
    if (cmd_disable)             enable_nxt = 1'b0;
    if (cmd_brk_start && enable) brk_nxt    = 1'b1;
    if (cmd_brk_stop)            brk_nxt    = 1'b0;
    if (cmd_reset) begin
      enable_nxt   = 1'b0;
      thr_full_nxt = 1'b0;
      brk_nxt      = 1'b0;
      drop_nxt     = 1'b0;
    end

    // THR emptiness is judged on the registered flag, so a write racing a handoff is dropped.
    if (i_Wr) begin
      if (enable_nxt && !thr_full) begin
        thr_full_nxt = 1'b1;
        thr_data_nxt = i_Wr_Data;
      end else if (!cmd_reset) begin
        drop_nxt = 1'b1;
      end
    end

    if (cmd_reset) begin
      gap_nxt   = 4'd0;
      state_nxt = (state == WAIT_START || state == SHIFTING) ? DRAIN : GAP;
    end else begin
      case (state)
        IDLE: begin
          // Break waits until the THR byte has gone out as well.
          if (brk_nxt && !thr_full) begin
            state_nxt = BREAK;
          end else if (thr_full && cts_ok) begin
            dv_nxt       = 1'b1;
            byte_nxt     = thr_data;
            thr_full_nxt = 1'b0;
            state_nxt    = WAIT_START;
          end
        end
        WAIT_START: begin
          if (core.tx_active) state_nxt = SHIFTING;
        end
        SHIFTING: begin
          if (core.tx_done) begin
            gap_nxt   = 4'd0;
            state_nxt = GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state_nxt = IDLE;
          end else begin
            gap_nxt = gap_cnt + 4'd1;
          end
        end
        BREAK: begin
          if (cmd_brk_stop) begin
            gap_nxt   = 4'd0;
            state_nxt = GAP;
          end
        end
        DRAIN: begin
          if (core.tx_done) begin
            gap_nxt   = 4'd0;
            state_nxt = GAP;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Pin source: only a character in flight reaches the line; the rest of the time it is forced.
    case (state)
      BREAK:                txd_src = 1'b0;
      WAIT_START, SHIFTING: txd_src = core.tx_serial;
      default:              txd_src = 1'b1;
    endcase
  end

  // Controller registers, including the registered status flags and the TxD pin.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= IDLE;
      enable    <= 1'b0;
      thr_full  <= 1'b0;
      thr_data  <= 8'h00;
      brk_pend  <= 1'b0;
      gap_cnt   <= 4'd0;
      dv_q      <= 1'b0;
      byte_q    <= 8'h00;
      o_Wr_Drop <= 1'b0;
      o_TxRDY   <= 1'b0;
      o_TxEMT   <= 1'b1;
      o_TXD     <= 1'b1;
    end else begin
      state     <= state_nxt;
      enable    <= enable_nxt;
      thr_full  <= thr_full_nxt;
      thr_data  <= thr_data_nxt;
      brk_pend  <= brk_nxt;
      gap_cnt   <= gap_nxt;
      dv_q      <= dv_nxt;
      byte_q    <= byte_nxt;
      o_Wr_Drop <= drop_nxt;
      o_TxRDY   <= enable_nxt & ~thr_full_nxt;
      o_TxEMT   <= ~thr_full_nxt & (state_nxt == IDLE);
      o_TXD     <= txd_src;
    end
  end

  assign core.tx_dv   = dv_q;
  assign core.tx_byte = byte_q;

endmodule
